// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
// Shares one AHB-lite master port between NUM_REQ requesters. A round-robin
// arbiter picks one pending request in IDLE, then the sequencer runs a single
// NONSEQ address phase and its data phase. It honours hready wait states,
// hresp ERROR and an optional data-phase watchdog. Completion is reported
// back to the granted requester.
//
// Ports
//   hclk, hrst        clock, synchronous active-high reset
//   req_valid/write   per-requester request strobe and direction
//   req_addr/wdata    packed 32-bit fields, requester i at [32i+31:32i]
//   req_ready         one-cycle acceptance pulse (first address-phase cycle)
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata/rsp_err read data and error flag, qualified by rsp_valid
//   hsel..hprot       AHB master outputs
//   hrdata/hready/hresp AHB slave responses
module ahb_master_arbiter #(
    parameter int         NUM_REQ   = 2,
    parameter int         TIMEOUT   = 16,
    parameter logic [3:0] HPROT_VAL = 4'h0
) (
    input  logic                   hclk,
    input  logic                   hrst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   hsel,
    output logic                   hwrite,
    output logic [1:0]             htrans,
    output logic [31:0]            haddr,
    output logic [31:0]            hwdata,
    output logic [3:0]             hprot,
    input  logic [31:0]            hrdata,
    input  logic                   hready,
    input  logic [1:0]             hresp
);

    localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // A disabled watchdog still gets a 1-bit counter so no vector is zero-width.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [GW-1:0]       grant_r, grant_s;
    logic [GW-1:0]       last_grant_r, last_grant_s;
    logic                wr_r, wr_s;
    logic [31:0]         wdata_r, wdata_s;
    logic [WD_W-1:0]     wd_r, wd_s, wd_inc_s;
    logic                timeout_hit_s;
    logic                hsel_r, hsel_s, hwrite_r, hwrite_s;
    logic [1:0]          htrans_r, htrans_s;
    logic [31:0]         haddr_r, haddr_s, hwdata_r, hwdata_s;
    logic [3:0]          hprot_r, hprot_s;
    logic [NUM_REQ-1:0]  req_ready_r, req_ready_s, rsp_valid_r, rsp_valid_s;
    logic [31:0]         rsp_rdata_r, rsp_rdata_s;
    logic                rsp_err_r, rsp_err_s;

    logic [31:0]         addr_arr_s  [NUM_REQ];
    logic [31:0]         wdata_arr_s [NUM_REQ];
    logic                hi_found_s, lo_found_s, any_req_s;
    logic [GW-1:0]       hi_idx_s, lo_idx_s, win_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
        onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr_s[g]  = req_addr[32*g +: 32];
        assign wdata_arr_s[g] = req_wdata[32*g +: 32];
    end

    // Round-robin pick: the lowest requester above last_grant wins; if none,
    // wrap around to the lowest requester at or below last_grant.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = {GW{1'b0}};
        lo_idx_s   = {GW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !hi_found_s && (GW'(i) > last_grant_r)) begin
                hi_found_s = 1'b1;
                hi_idx_s   = GW'(i);
            end else if (req_valid[i] && !lo_found_s && (GW'(i) <= last_grant_r)) begin
                lo_found_s = 1'b1;
                lo_idx_s   = GW'(i);
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        any_req_s = hi_found_s | lo_found_s;
        win_s     = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Saturating watchdog increment and expiry detect for the data phase.
    always_comb begin
        wd_inc_s      = (wd_r == {WD_W{1'b1}}) ? wd_r : (wd_r + {{(WD_W-1){1'b0}}, 1'b1});
        timeout_hit_s = (TIMEOUT != 0) && (wd_inc_s == WD_W'(TIMEOUT));
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        wr_s         = wr_r;
        wdata_s      = wdata_r;
        wd_s         = wd_r;
        hsel_s       = hsel_r;
        hwrite_s     = hwrite_r;
        htrans_s     = htrans_r;
        haddr_s      = haddr_r;
        hwdata_s     = hwdata_r;
        hprot_s      = hprot_r;
        req_ready_s  = {NUM_REQ{1'b0}};
        rsp_valid_s  = {NUM_REQ{1'b0}};
        rsp_rdata_s  = rsp_rdata_r;
        rsp_err_s    = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s     = ST_ADDR;
                    grant_s     = win_s;
                    wr_s        = req_write[win_s];
                    wdata_s     = wdata_arr_s[win_s];
                    hsel_s      = 1'b1;
                    htrans_s    = 2'b10;
                    haddr_s     = addr_arr_s[win_s];
                    hwrite_s    = req_write[win_s];
                    hprot_s     = HPROT_VAL;
                    req_ready_s = onehot(win_s);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    state_s  = ST_DATA;
                    hsel_s   = 1'b0;
                    htrans_s = 2'b00;
                    hwrite_s = 1'b0;
                    // Reads leave the write-data bus untouched.
                    hwdata_s = wr_r ? wdata_r : hwdata_r;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (hready) begin
                    state_s     = ST_RESP;
                    rsp_rdata_s = wr_r ? rsp_rdata_r : hrdata;
                    rsp_err_s   = (hresp == 2'b01);
                    rsp_valid_s = onehot(grant_r);
                end else if (timeout_hit_s) begin
                    state_s     = ST_RESP;
                    wd_s        = wd_inc_s;
                    rsp_err_s   = 1'b1;
                    rsp_valid_s = onehot(grant_r);
                end else begin
                    wd_s = wd_inc_s;
                end
            end
            ST_RESP: begin
                state_s      = ST_IDLE;
                last_grant_s = grant_r;
                wd_s         = {WD_W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_r      <= ST_IDLE;
            grant_r      <= {GW{1'b0}};
            last_grant_r <= GW'(NUM_REQ - 1);
            wr_r         <= 1'b0;
            wdata_r      <= 32'h0000_0000;
            wd_r         <= {WD_W{1'b0}};
            hsel_r       <= 1'b0;
            hwrite_r     <= 1'b0;
            htrans_r     <= 2'b00;
            haddr_r      <= 32'h0000_0000;
            hwdata_r     <= 32'h0000_0000;
            hprot_r      <= 4'h0;
            req_ready_r  <= {NUM_REQ{1'b0}};
            rsp_valid_r  <= {NUM_REQ{1'b0}};
            rsp_rdata_r  <= 32'h0000_0000;
            rsp_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            wr_r         <= wr_s;
            wdata_r      <= wdata_s;
            wd_r         <= wd_s;
            hsel_r       <= hsel_s;
            hwrite_r     <= hwrite_s;
            htrans_r     <= htrans_s;
            haddr_r      <= haddr_s;
            hwdata_r     <= hwdata_s;
            hprot_r      <= hprot_s;
            req_ready_r  <= req_ready_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_rdata_r  <= rsp_rdata_s;
            rsp_err_r    <= rsp_err_s;
        end
    end

    assign hsel      = hsel_r;
    assign hwrite    = hwrite_r;
    assign htrans    = htrans_r;
    assign haddr     = haddr_r;
    assign hwdata    = hwdata_r;
    assign hprot     = hprot_r;
    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
module tb_ahb_master_arbiter;

    localparam int         NR = 3;
    localparam int         TO = 16;
    localparam logic [3:0] HP = 4'hA;

    logic               hclk = 1'b0;
    logic               hrst;
    logic [NR-1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [NR*32-1:0]   req_addr, req_wdata;
    logic [31:0]        rsp_rdata, haddr, hwdata, hrdata;
    logic               rsp_err, hsel, hwrite, hready;
    logic [1:0]         htrans, hresp;
    logic [3:0]         hprot;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: what each requester posted, who was served last,
    // and the values the bus/response outputs should currently be holding.
    logic [31:0] m_addr [NR];
    logic [31:0] m_wdata [NR];
    bit          m_write [NR];
    int          m_last;
    logic [31:0] m_hwdata, m_rdata;

    ahb_master_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO), .HPROT_VAL(HP)) dut (
        .hclk(hclk), .hrst(hrst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .hsel(hsel), .hwrite(hwrite), .htrans(htrans),
        .haddr(haddr), .hwdata(hwdata), .hprot(hprot),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Round-robin rule: first pending requester after the last served one.
    function automatic int rr_pick();
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (m_last + k) % NR;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic post(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        m_addr[i] = a;
        m_wdata[i] = d;
        m_write[i] = wr;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = d;
        req_write[i] = wr;
        req_valid[i] = 1'b1;
    endtask

    // One complete transfer starting from an IDLE-cycle negedge with requests
    // already posted. aw/dw are slave wait states in address/data phase;
    // dw >= TO means the slave never answers and the watchdog must fire.
    task automatic run_xfer(input string name, input int aw, input int dw,
                            input bit err, input logic [31:0] rd);
        int w, lat, d;
        bit tmo, ew, exp_hsel, exp_err;
        logic [31:0] ea, ed;
        logic [NR-1:0] exp_vec;
        w = rr_pick();
        if (w < 0) begin
            vectors++; miscompares++;
            $display("FAIL %s: bench has no pending request", name);
            return;
        end
        ea = m_addr[w]; ed = m_wdata[w]; ew = m_write[w];
        tmo = (dw >= TO);
        lat = tmo ? (2 + aw + TO) : (3 + aw + dw);
        for (int c = 1; c <= lat; c++) begin
            @(negedge hclk);
            exp_hsel = (c <= aw + 1);
            vectors++;
            if (hsel !== exp_hsel) begin
                miscompares++;
                $display("FAIL %s hsel cyc%0d: got %b want %b", name, c, hsel, exp_hsel);
            end
            vectors++;
            if (htrans !== (exp_hsel ? 2'b10 : 2'b00) || hwrite !== (exp_hsel & ew)) begin
                miscompares++;
                $display("FAIL %s htrans/hwrite cyc%0d: got %b/%b want %b/%b", name, c,
                         htrans, hwrite, exp_hsel ? 2'b10 : 2'b00, exp_hsel & ew);
            end
            if (exp_hsel) begin
                vectors++;
                if (haddr !== ea || hprot !== HP) begin
                    miscompares++;
                    $display("FAIL %s haddr/hprot cyc%0d: got %h/%h want %h/%h", name, c, haddr, hprot, ea, HP);
                end
            end
            exp_vec = (c == 1) ? NR'(1 << w) : '0;
            vectors++;
            if (req_ready !== exp_vec) begin
                miscompares++;
                $display("FAIL %s req_ready cyc%0d: got %b want %b", name, c, req_ready, exp_vec);
            end
            if (c == aw + 2) begin
                if (ew) m_hwdata = ed;
                vectors++;
                if (hwdata !== m_hwdata) begin
                    miscompares++;
                    $display("FAIL %s hwdata: got %h want %h", name, hwdata, m_hwdata);
                end
            end
            exp_vec = (c == lat) ? NR'(1 << w) : '0;
            vectors++;
            if (rsp_valid !== exp_vec) begin
                miscompares++;
                $display("FAIL %s rsp_valid cyc%0d: got %b want %b", name, c, rsp_valid, exp_vec);
            end
            if (c == lat) begin
                if (!ew && !tmo) m_rdata = rd;
                exp_err = tmo | err;
                vectors++;
                if (rsp_rdata !== m_rdata || rsp_err !== exp_err) begin
                    miscompares++;
                    $display("FAIL %s rsp_rdata/err: got %h/%b want %h/%b", name, rsp_rdata, rsp_err, m_rdata, exp_err);
                end
            end
            if (c == 1) begin
                // Requester sees its pulse, withdraws and scribbles its fields.
                req_valid[w] = 1'b0;
                req_addr[w*32 +: 32] = $urandom;
                req_wdata[w*32 +: 32] = $urandom;
                req_write[w] = ~ew;
            end
            hresp = 2'b00;
            if (c <= aw) begin
                hready = 1'b0;
            end else if (c == aw + 1) begin
                hready = 1'b1;
            end else if (c < lat) begin
                d = c - (aw + 2);
                if (!tmo && d == dw) begin
                    hready = 1'b1;
                    hresp = err ? 2'b01 : 2'b00;
                    hrdata = rd;
                end else begin
                    hready = 1'b0;
                    hrdata = $urandom;
                end
            end else begin
                hready = 1'b1;
            end
        end
        @(negedge hclk);
        vectors++;
        if (rsp_valid !== '0 || req_ready !== '0 || hsel !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle after resp: rsp_valid %b req_ready %b hsel %b", name, rsp_valid, req_ready, hsel);
        end
        m_last = w;
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if ({hsel, htrans, hwrite, haddr, hwdata, hprot, req_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
            miscompares++;
            $display("FAIL %s outputs: got hsel %b htrans %b hwrite %b haddr %h hwdata %h hprot %h rr %b rv %b rdata %h err %b, want all 0",
                     name, hsel, htrans, hwrite, haddr, hwdata, hprot, req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_reset();
        hrst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        hready = 1'b1; hresp = 2'b00; hrdata = 32'h0;
        repeat (3) @(negedge hclk);
        check_all_zero("reset");
        hrst = 1'b0;
        m_last = NR - 1; m_hwdata = 32'h0; m_rdata = 32'h0;
    endtask

    task automatic test_single_write();
        post(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        run_xfer("single_write", 0, 0, 1'b0, 32'hFFFF_0000);
    endtask

    task automatic test_read_wait();
        post(1, 1'b0, 32'h0000_0020, 32'h0);
        run_xfer("read_wait2", 0, 2, 1'b0, 32'h1234_5678);
    endtask

    task automatic test_back_to_back();
        post(0, 1'b0, 32'h0000_0100, 32'h1111_1111);
        post(1, 1'b1, 32'h0000_0200, 32'h2222_2222);
        for (int n = 0; n < 4; n++) begin
            int prev;
            run_xfer("back_to_back", 0, 0, 1'b0, $urandom);
            prev = m_last;
            if (n < 2) post(prev, m_write[prev], m_addr[prev] + 32'h4, m_wdata[prev] ^ 32'hFF);
        end
    endtask

    task automatic test_error();
        post(2, 1'b1, 32'h0000_0300, 32'hCAFE_F00D);
        run_xfer("err_write", 1, 0, 1'b1, 32'h0);
        post(0, 1'b0, 32'h0000_0304, 32'h0);
        run_xfer("after_err", 0, 1, 1'b0, 32'hA5A5_5A5A);
    endtask

    task automatic test_timeout();
        post(1, 1'b0, 32'h0000_0400, 32'h0);
        run_xfer("timeout", 0, TO + 4, 1'b0, 32'h0);
        post(1, 1'b0, 32'h0000_0404, 32'h0);
        run_xfer("timeout_stall15", 0, TO - 1, 1'b0, 32'h0BAD_CAFE);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int aw, dw;
            bit err;
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (req_valid == '0) post(int'($urandom_range(0, NR - 1)), 1'b0, $urandom, $urandom);
            aw = $urandom_range(0, 2);
            dw = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 3);
            err = ($urandom_range(0, 5) == 0);
            run_xfer("random", aw, dw, err, $urandom);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        req_valid = '0;
        post(1, 1'b0, 32'h0000_0500, 32'h0);
        @(negedge hclk);
        vectors++;
        if (req_ready !== 3'b010) begin
            miscompares++;
            $display("FAIL rst_mid req_ready: got %b want 010", req_ready);
        end
        req_valid[1] = 1'b0;
        hready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge hclk);
            vectors++;
            if (rsp_valid !== '0) begin
                miscompares++;
                $display("FAIL rst_mid rsp_valid before reset: got %b want 000", rsp_valid);
            end
            hready = 1'b0;
        end
        hrst = 1'b1;
        post(0, 1'b1, 32'h0000_0600, 32'h6666_6666);
        post(1, 1'b1, 32'h0000_0610, 32'h7777_7777);
        post(2, 1'b1, 32'h0000_0620, 32'h8888_8888);
        @(negedge hclk);
        check_all_zero("rst_mid");
        hrst = 1'b0; hready = 1'b1;
        m_last = NR - 1; m_hwdata = 32'h0; m_rdata = 32'h0;
        run_xfer("rst_mid_next", 0, 0, 1'b0, 32'h0);
        // Remaining requesters withdraw before being granted: nothing starts.
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge hclk);
            vectors++;
            if (req_ready !== '0 || hsel !== 1'b0 || rsp_valid !== '0) begin
                miscompares++;
                $display("FAIL dropped_req: got req_ready %b hsel %b rsp_valid %b want 0", req_ready, hsel, rsp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_error();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
